// File: rtl/cim_ibuf_rx.sv
// cim_ibuf_rx: CIM-side row buffer for the conv controller write stream.
// Rows are captured in IDLE. A commit (i_ctrl_busy low with rows held, or with a
// write accepted the same cycle) streams rows 0..rows-1 to the crossbar over
// valid/ready. o_busy then stays high until i_xbar_done arrives in WAIT.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_we, i_addr, i_data          row write from controller
//   i_ctrl_busy                   controller busy; low with rows held = commit
//   o_busy                        busy back to controller
//   o_xbar_valid/addr/data/last   row stream to crossbar
//   i_xbar_ready                  crossbar accepts the presented row
//   i_xbar_done                   crossbar compute finished
//   o_drop_cnt                    dropped write beats, saturating
//                                 (present only with CIM_IBUF_RX_DROPCNT_EN)
module cim_ibuf_rx #(
  parameter int datatype_size = 8,
  parameter int xbar_size     = 256,
  parameter int v_cim_tiles   = 1,
  localparam int AW = $clog2(xbar_size)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_we,
  input  logic [AW-1:0]                             i_addr,
  input  logic [v_cim_tiles-1:0][datatype_size-1:0] i_data,
  input  logic                                      i_ctrl_busy,
  output logic                                      o_busy,
  output logic                                      o_xbar_valid,
  input  logic                                      i_xbar_ready,
  output logic [AW-1:0]                             o_xbar_addr,
  output logic [v_cim_tiles-1:0][datatype_size-1:0] o_xbar_data,
  output logic                                      o_xbar_last,
`ifdef CIM_IBUF_RX_DROPCNT_EN
  output logic [15:0]                               o_drop_cnt,
`endif
  input  logic                                      i_xbar_done
);

  typedef logic [v_cim_tiles-1:0][datatype_size-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WAIT
  } state_t;

  localparam logic [AW:0] XS = (AW+1)'(xbar_size);

  state_t      r_state;
  state_t      w_next;
  row_t        r_buf [xbar_size];
  row_t        r_rd_data;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0] r_rows;

  logic        w_in_range;
  logic        w_wr_ok;
  logic [AW:0] w_addr_p1;
  logic        w_hs;
  logic        w_last;
  logic        w_commit;

  assign w_in_range = ({1'b0, i_addr} < XS);
  assign w_wr_ok    = i_we && (r_state == S_IDLE) && w_in_range;
  assign w_addr_p1  = {1'b0, i_addr} + 1'b1;
  assign w_hs       = o_xbar_valid && i_xbar_ready;
  assign w_last     = (r_state == S_DRAIN)
                   && ({1'b0, r_rd_ptr} == r_rows - 1'b1);
  // A write accepted in the commit cycle joins the frame.
  assign w_commit   = !i_ctrl_busy && ((r_rows != '0) || w_wr_ok);

  assign o_busy       = (r_state != S_IDLE);
  assign o_xbar_valid = (r_state == S_DRAIN);
  assign o_xbar_addr  = r_rd_ptr;
  assign o_xbar_data  = r_rd_data;
  assign o_xbar_last  = w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_commit) w_next = S_LOAD;
      S_LOAD:  w_next = S_DRAIN;
      S_DRAIN: if (w_hs && w_last) w_next = S_WAIT;
      S_WAIT:  if (i_xbar_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Buffer is never cleared; only rows below r_rows are streamed.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_buf[i_addr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows    <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_ok && (w_addr_p1 > r_rows))
        r_rows <= w_addr_p1;
      if ((r_state == S_WAIT) && i_xbar_done)
        r_rows <= '0;
      // Registered read: the next row is fetched on the
      // accepting handshake so full rate needs no bubble.
      if (r_state == S_LOAD) begin
        r_rd_ptr  <= '0;
        r_rd_data <= r_buf[0];
      end else if (w_hs && !w_last) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_buf[r_rd_ptr + 1'b1];
      end
    end
  end

`ifdef CIM_IBUF_RX_DROPCNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (i_we && !w_wr_ok && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
